ysyx_23060184_lsu_axi: RTL
==========================

# ysyx_23060184_lsu_axi

AXI-lite-style bus initiator that turns single load/store requests from the core's memory stage into read or write transactions towards the SRAM responder. One transaction is in flight at a time. The block handles byte/half/word sizing, write-strobe generation, load extraction with sign/zero extension and misalignment detection. It returns a one-cycle response pulse to the core.

## Interface
- DATA_WIDTH, 32, address and data width (matches `DATA_WIDTH)
- RESP_WIDTH, 2, bus response width (matches `ACERR_WIDTH)
- STRB_WIDTH, 4, write strobe width (matches `WMASK_LENGTH)

- clk  in  1  single clock, all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- req_valid  in  1  core request present
- req_ready  out  1  block idle, request accepted on valid&&ready
- req_wen  in  1  1 = store, 0 = load
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-aligned
- req_size  in  2  0 byte, 1 half, 2 word; 3 illegal (treated as misaligned)
- req_signed  in  1  load sign-extend when 1
- resp_valid  out  1  one-cycle completion pulse
- resp_rdata  out  32  extended load data (0 for stores)
- resp_err  out  2  bus response or local error 2'b10
- araddr  out  32, arvalid  out  1, arready  in  1  read address channel
- rdata  in  32, rresp  in  2, rvalid  in  1, rready  out  1  read data channel
- awaddr  out  32, awvalid  out  1, awready  in  1  write address channel
- wdata  out  32, wstrb  out  4, wvalid  out  1, wready  in  1  write data channel
- bresp  in  2, bvalid  in  1, bready  out  1  write response channel

## Operation
- States: IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP, DONE.
- IDLE: req_ready=1. On accept, latch addr, size, signed, wen and wdata. Check alignment: half needs addr[0]=0, word needs addr[1:0]=0, size 3 is always misaligned.
  - Misaligned -> DONE with resp_err=2'b10. No bus activity.
  - Aligned load -> RD_ADDR.
  - Aligned store -> WR_REQ.
- Bus address is always req_addr & ~3.
- RD_ADDR: arvalid=1. On arvalid&&arready -> RD_DATA.
- RD_DATA: rready=1. On rvalid&&rready, capture rdata and rresp -> DONE.
- Load extraction: select the byte/half at addr[1:0]/addr[1]. Sign-extend if req_signed, else zero-extend. A word load passes through.
- WR_REQ: awvalid and wvalid rise together.
  - Each drops independently after its own handshake.
  - When both handshakes are complete (including in the same cycle) -> WR_RESP.
- Store shaping: wdata = req_wdata shifted left by 8*addr[1:0]. wstrb = 4'b0001/0011/1111 shifted left by addr[1:0].
- WR_RESP: bready=1. On bvalid&&bready, capture bresp -> DONE.
- DONE: resp_valid=1 for exactly one cycle -> IDLE.
- AXI rules:
  - A valid is never withdrawn before its handshake.
  - araddr, awaddr, wdata and wstrb stay stable while their valid is high.
  - rready and bready are high only in their own states.
- Requests presented while not in IDLE are ignored (req_ready=0).

## Timing
- Reset values:
  - state IDLE.
  - All valid/ready outputs 0, except req_ready, which is 0 during the rst cycle and 1 from the first cycle after.
  - resp_valid 0, resp_rdata 0, resp_err 0.
  - araddr, awaddr, wdata and wstrb all 0.
- Reset mid-transaction abandons it immediately. All valids drop in the next cycle. No resp_valid is issued for the abandoned request.
- Minimum load latency, with arready and rvalid already high: accept at cycle 0, arvalid at cycle 1, rready at cycle 2, resp_valid at cycle 3.
- Minimum store latency: accept at cycle 0, aw/w at cycle 1, bready at cycle 2, resp_valid at cycle 3.
- Misaligned request: resp_valid at cycle 1.
- The next request can be accepted in the cycle after resp_valid. Back-to-back throughput is 1 request per 4 cycles minimum.
- Wait states on any channel extend latency one cycle each. There is no timeout.

## Test plan
- Word load 0x80000004, responder returns 0xDEADBEEF with rresp=0, zero wait states -> araddr=0x80000004, resp_valid at cycle 3, resp_rdata=0xDEADBEEF, resp_err=0.
- Signed byte load at 0x80000003, bus data 0x80FF1234 -> araddr=0x80000000, resp_rdata=0xFFFFFF80. Same request unsigned -> 0x00000080.
- Half store 0xABCD at 0x80000002, with wready delayed 3 cycles after awready -> awaddr=0x80000000, wdata=0xABCD0000, wstrb=4'b1100. awvalid drops after its handshake while wvalid is held. bready rises only after the w handshake.
- Word load at 0x80000002 -> no arvalid ever. resp_valid at cycle 1 with resp_err=2'b10.
- Store whose responder returns bresp=2'b10 -> resp_err=2'b10, resp_rdata=0. A new request is accepted in the cycle after resp_valid.
- rst asserted while in RD_DATA with rvalid held low -> rready, arvalid and resp_valid are 0 in the next cycle and req_ready=1 the cycle after. A fresh load then completes normally.

Source files
------------

// File: rtl/ysyx_23060184_lsu_axi.sv
// Load/store unit bus initiator: turns one core memory request into one AXI-lite read or write.
// Latency: 3 cycles accept-to-response with zero wait states, 1 cycle for misaligned requests.
// Backpressure: req_ready only in IDLE; bus wait states stretch the transaction, no timeout.
module ysyx_23060184_lsu_axi #(
  parameter int DATA_WIDTH = 32,
  parameter int RESP_WIDTH = 2,
  parameter int STRB_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_wen,
  input  logic [DATA_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  input  logic [1:0]            req_size,
  input  logic                  req_signed,
  output logic                  resp_valid,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic [RESP_WIDTH-1:0] resp_err,
  output logic [DATA_WIDTH-1:0] araddr,
  output logic                  arvalid,
  input  logic                  arready,
  input  logic [DATA_WIDTH-1:0] rdata,
  input  logic [RESP_WIDTH-1:0] rresp,
  input  logic                  rvalid,
  output logic                  rready,
  output logic [DATA_WIDTH-1:0] awaddr,
  output logic                  awvalid,
  input  logic                  awready,
  output logic [DATA_WIDTH-1:0] wdata,
  output logic [STRB_WIDTH-1:0] wstrb,
  output logic                  wvalid,
  input  logic                  wready,
  input  logic [RESP_WIDTH-1:0] bresp,
  input  logic                  bvalid,
  output logic                  bready
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_ADDR = 3'd1,
    RD_DATA = 3'd2,
    WR_REQ  = 3'd3,
    WR_RESP = 3'd4,
    DONE    = 3'd5
  } state_t;

  localparam logic [RESP_WIDTH-1:0] ERR_LOCAL = RESP_WIDTH'(2'b10);

  state_t                  state;
  state_t                  state_nxt;
  logic [DATA_WIDTH-1:0]   addr_q;
  logic [1:0]              size_q;
  logic                    sgn_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic [STRB_WIDTH-1:0]   wstrb_q;
  logic                    aw_done;
  logic                    w_done;
  logic [DATA_WIDTH-1:0]   load_q;
  logic [RESP_WIDTH-1:0]   err_q;

  logic                    accept;
  logic                    misaligned;
  logic [STRB_WIDTH-1:0]   strb_base;
  logic [DATA_WIDTH-1:0]   load_ext;
  logic [7:0]              load_byte;
  logic [15:0]             load_half;

  // Requests are only taken in IDLE and never in the reset cycle itself.
  assign accept = req_valid && (state == IDLE) && !rst;

  // Alignment check and strobe pattern for the incoming request.
  always_comb begin
    misaligned = 1'b0;
    strb_base  = '0;
    case (req_size)
      2'd0: strb_base = STRB_WIDTH'(4'b0001);
      2'd1: begin
        strb_base  = STRB_WIDTH'(4'b0011);
        misaligned = req_addr[0];
      end
      2'd2: begin
        strb_base  = STRB_WIDTH'(4'b1111);
        misaligned = (req_addr[1:0] != 2'b00);
      end
      default: misaligned = 1'b1;
    endcase
  end

  // Pick the addressed byte/half out of the returned bus word and extend it.
  always_comb begin
    load_byte = rdata[{addr_q[1:0], 3'b000} +: 8];
    load_half = rdata[{addr_q[1], 4'b0000} +: 16];
    load_ext  = rdata;
    case (size_q)
      2'd0:    load_ext = {{(DATA_WIDTH-8){sgn_q & load_byte[7]}}, load_byte};
      2'd1:    load_ext = {{(DATA_WIDTH-16){sgn_q & load_half[15]}}, load_half};
      default: load_ext = rdata;
    endcase
  end

  // State register; reset abandons any transaction in flight.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state and handshake outputs, all decoded from the current state.
  always_comb begin
    state_nxt  = state;
    req_ready  = 1'b0;
    arvalid    = 1'b0;
    rready     = 1'b0;
    awvalid    = 1'b0;
    wvalid     = 1'b0;
    bready     = 1'b0;
    resp_valid = 1'b0;
    case (state)
      IDLE: begin
        req_ready = !rst;
        if (accept) begin
          if (misaligned)   state_nxt = DONE;
          else if (req_wen) state_nxt = WR_REQ;
          else              state_nxt = RD_ADDR;
        end
      end
      RD_ADDR: begin
        arvalid = 1'b1;
        if (arready) state_nxt = RD_DATA;
      end
      RD_DATA: begin
        rready = 1'b1;
        if (rvalid) state_nxt = DONE;
      end
      WR_REQ: begin
        // Address and data channels complete independently, possibly together.
        awvalid = !aw_done;
        wvalid  = !w_done;
        if ((aw_done || awready) && (w_done || wready)) state_nxt = WR_RESP;
      end
      WR_RESP: begin
        bready = 1'b1;
        if (bvalid) state_nxt = DONE;
      end
      DONE: begin
        resp_valid = 1'b1;
        state_nxt  = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Request latch, store shaping, per-channel done flags and response capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q  <= '0;
      size_q  <= '0;
      sgn_q   <= 1'b0;
      wdata_q <= '0;
      wstrb_q <= '0;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
      load_q  <= '0;
      err_q   <= '0;
    end else begin
      if (accept) begin
        addr_q  <= req_addr;
        size_q  <= req_size;
        sgn_q   <= req_signed;
        wdata_q <= req_wdata << {req_addr[1:0], 3'b000};
        wstrb_q <= strb_base << req_addr[1:0];
        aw_done <= 1'b0;
        w_done  <= 1'b0;
        load_q  <= '0;
        err_q   <= misaligned ? ERR_LOCAL : '0;
      end
      if (awvalid && awready) aw_done <= 1'b1;
      if (wvalid && wready)   w_done  <= 1'b1;
      if (rvalid && rready) begin
        load_q <= load_ext;
        err_q  <= rresp;
      end
      if (bvalid && bready) err_q <= bresp;
    end
  end

  assign araddr     = {addr_q[DATA_WIDTH-1:2], 2'b00};
  assign awaddr     = {addr_q[DATA_WIDTH-1:2], 2'b00};
  assign wdata      = wdata_q;
  assign wstrb      = wstrb_q;
  assign resp_rdata = load_q;
  assign resp_err   = err_q;

endmodule
